ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Writer side of the configuration-chain protocol used by the routing and connection blocks.
- Accepts configuration words over a valid/ready stream and serialises them MSB-first onto a block's ccff_head.
- Asserts a shift enable that gates the chain's programming clock, counts exactly CHAIN_LEN shifts, and monitors ccff_tail for integrity.
- One instance sits at the head of each programmable-fabric configuration chain.

Parameters:
- CHAIN_LEN, 58, number of configuration flops in the chain; 9 six-input muxes x 6 bits + 2 two-input muxes x 2 bits. Legal range 1..65535.
- WORD_W, 8, width of the input configuration word. Legal range 1..32.
- CHECK_EMPTY, 1, when 1, any ccff_tail=1 sampled during a load sets tail_err (chain must hold post-reset zeros).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle load request; honoured only in IDLE.
- cfg_data  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit to chain head.
- chain_shift_en  output  1  chain advances on this prog_clk edge; drives the chain clock gate.
- ccff_tail  input  1  serial bit from chain tail.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when load completes.
- tail_err  output  1  sticky integrity error; cleared by next accepted start.
- bit_cnt  output  16  number of bits shifted in the current or last load.

Behaviour:
- Reset values (asynchronous on pReset=1): state=IDLE, shift register=0, bits_in_sr=0, bit_cnt=0. All outputs 0: ccff_head, chain_shift_en, cfg_ready, busy, done, tail_err.
- States:
  - IDLE -> LOAD on start=1. Clears bit_cnt, tail_err and the shift register.
  - LOAD -> DONE when the shift that makes bit_cnt==CHAIN_LEN occurs.
  - DONE -> IDLE after exactly one cycle. done=1 only in DONE.
- start in LOAD or DONE: ignored.
- Word intake in LOAD:
  - cfg_ready = (bits_in_sr==0) || (bits_in_sr==1 && chain_shift_en), and only while bit_cnt + bits_in_sr < CHAIN_LEN.
  - A word is accepted when cfg_valid && cfg_ready; it loads the shift register with bits_in_sr=WORD_W on that edge.
  - No double buffering: one-bubble-free back-to-back when the source holds valid.
- Shifting:
  - chain_shift_en = (state==LOAD) && (bits_in_sr>0), registered-free combinational from state.
  - ccff_head = shift register MSB, valid only when chain_shift_en=1; 0 otherwise.
  - Each shift: shift register moves left, bits_in_sr decrements, bit_cnt increments.
- Partial last word: when CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the final word are shifted; the remaining bits are discarded when the state leaves LOAD.
- Source starvation: if bits_in_sr==0 and cfg_valid=0, chain_shift_en=0. The chain holds and no bits are lost.
- Tail check: ccff_tail is sampled on every edge with chain_shift_en=1. This is the pre-shift value of the last chain flop. If CHECK_EMPTY=1 and the sample is 1, tail_err is set and stays set until the next accepted start.
- Extra words offered after CHAIN_LEN bits are covered are not accepted (cfg_ready=0).
- pReset mid-load: immediate return to IDLE with all reset values. The chain is expected to be reset by the same pReset.
- Latency: first bit appears on ccff_head in the cycle after the first accepted word. A full load with continuous valid takes CHAIN_LEN shift cycles + 1 intake cycle + 1 DONE cycle.

Test Plan:
- Reset, start, then 8 words 0xA5 each with continuous valid (CHAIN_LEN=58, WORD_W=8) -> chain_shift_en high for exactly 58 consecutive cycles. ccff_head reads 1010_0101 repeated, and the last word contributes only bits 1,0. done pulses once, bit_cnt=58, tail_err=0.
- Same load with cfg_valid dropped for 3 cycles after word 3 -> chain_shift_en low for those cycles, no bit lost or duplicated, total shifts still 58.
- Force ccff_tail=1 on shift number 10 only -> tail_err=1 at end and stays 1. Next start clears it to 0.
- Assert pReset at bit_cnt=30 -> busy, chain_shift_en, cfg_ready=0 immediately. A new start then loads a full 58 bits from bit 0.
- Pulse start during LOAD and offer a 9th word after 58 bits are covered -> start ignored, the 9th word is never accepted (cfg_ready=0), single done pulse.
- CHAIN_LEN=4, WORD_W=8, word 0xF0 -> ccff_head bits 1,1,1,1, then done. The low nibble is discarded.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Configuration-chain writer: takes words over valid/ready and shifts them MSB-first
// onto ccff_head, gating the chain clock via chain_shift_en for exactly CHAIN_LEN shifts.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN   = 58,
  parameter int unsigned WORD_W      = 8,
  parameter bit          CHECK_EMPTY = 1'b1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_err,
  output logic [15:0]       bit_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [16:0] LEN17     = 17'(CHAIN_LEN);
  localparam logic [15:0] LAST_CNT  = 16'(CHAIN_LEN - 1);
  localparam logic [5:0]  WORD_BITS = 6'(WORD_W);

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [5:0]        bits_in_sr;
  logic              room;
  logic              accept;

  assign chain_shift_en = (state == LOAD) && (bits_in_sr != 6'd0);
  assign ccff_head      = chain_shift_en & sr[WORD_W-1];

  // Stop taking words once the bits already held cover the rest of the chain.
  assign room      = ({1'b0, bit_cnt} + {11'b0, bits_in_sr}) < LEN17;
  assign cfg_ready = (state == LOAD) && room &&
                     ((bits_in_sr == 6'd0) || ((bits_in_sr == 6'd1) && chain_shift_en));
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state      <= IDLE;
      sr         <= '0;
      bits_in_sr <= 6'd0;
      bit_cnt    <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tail_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            bit_cnt    <= 16'd0;
            tail_err   <= 1'b0;
            sr         <= '0;
            bits_in_sr <= 6'd0;
          end
        end
        LOAD: begin
          if (chain_shift_en) begin
            sr         <= sr << 1;
            bits_in_sr <= bits_in_sr - 6'd1;
            bit_cnt    <= bit_cnt + 16'd1;
            if (CHECK_EMPTY && ccff_tail) tail_err <= 1'b1;
            // Final shift: any unshifted low bits of a partial word are dropped here.
            if (bit_cnt == LAST_CNT) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              sr         <= '0;
              bits_in_sr <= 6'd0;
            end
          end
          if (accept) begin
            sr         <= cfg_data;
            bits_in_sr <= WORD_BITS;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: table of full loads with a bit-level scoreboard on ccff_head,
// plus hand sequences for mid-load reset and a short chain with a partial word.
module tb_ccff_chain_loader;
  localparam int CL = 58;
  localparam int WW = 8;

  logic       prog_clk = 1'b0;
  logic       pReset = 1'b1;
  logic       start = 1'b0, cfg_valid = 1'b0, ccff_tail = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready, ccff_head, chain_shift_en, busy, done, tail_err;
  logic [15:0] bit_cnt;

  logic       start4 = 1'b0, cfg_valid4 = 1'b0;
  logic [7:0] cfg_data4 = 8'h00;
  logic       cfg_ready4, head4, shift_en4, busy4, done4, tail_err4;
  logic [15:0] bit_cnt4;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CHECK_EMPTY(1'b1)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .chain_shift_en(chain_shift_en), .ccff_tail(ccff_tail), .busy(busy),
    .done(done), .tail_err(tail_err), .bit_cnt(bit_cnt));

  ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(8), .CHECK_EMPTY(1'b1)) dut4 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start4), .cfg_data(cfg_data4),
    .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4), .ccff_head(head4),
    .chain_shift_en(shift_en4), .ccff_tail(1'b0), .busy(busy4),
    .done(done4), .tail_err(tail_err4), .bit_cnt(bit_cnt4));

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [7:0] word;
    int         gap_after;
    int         tail_at;
    int         start_mid;
    int         n_words;
    int         exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];
  int   pushed, shifts, busy_cyc, done_cnt, acc_cnt;
  int   tail_at = -1;
  bit   acc;
  logic [3:0] h4;
  int   n4, acc4, done4_cnt;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample mid-cycle, then drive just after the rising edge.
  task automatic tick();
    @(negedge prog_clk);
    acc = cfg_valid && cfg_ready;
    if (acc) begin
      acc_cnt++;
      for (int i = WW - 1; i >= 0; i--) begin
        if (pushed < CL) begin
          exp_q.push_back(cfg_data[i]);
          pushed++;
        end
      end
    end
    if (chain_shift_en) begin
      shifts++;
      if (exp_q.size() == 0) check("head_extra_shift", 1, 0);
      else check("head_bit", int'(ccff_head), int'(exp_q.pop_front()));
    end else begin
      check("head_idle", int'(ccff_head), 0);
    end
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (cfg_valid4 && cfg_ready4) acc4++;
    if (shift_en4) begin
      h4 = {h4[2:0], head4};
      n4++;
    end
    if (done4) done4_cnt++;
    @(posedge prog_clk);
    #1;
    ccff_tail = (tail_at >= 0) && chain_shift_en && (int'(bit_cnt) == tail_at);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    pushed = 0; shifts = 0; busy_cyc = 0; done_cnt = 0; acc_cnt = 0;
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int words, gapcnt, cyc;
    clear_sb();
    tail_at = v.tail_at;
    words = 0; gapcnt = 0; cyc = 0;
    cfg_data = v.word;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1;
    while (done_cnt == 0 && cyc < 300) begin
      tick();
      cyc++;
      if (acc) begin
        words++;
        if (words == v.gap_after) gapcnt = 10;
      end
      cfg_valid = (gapcnt == 0) && (words < v.n_words);
      if (gapcnt > 0) gapcnt--;
      start = (v.start_mid != 0) && (cyc == v.start_mid);
    end
    if (cyc >= 300) check({tag, "_timeout"}, 1, 0);
    cfg_valid = 1'b0;
    start = 1'b0;
    check({tag, "_tail_err"}, int'(tail_err), int'(v.exp_err));
    check({tag, "_bit_cnt"}, int'(bit_cnt), CL);
    check({tag, "_shifts"}, shifts, CL);
    check({tag, "_words"}, acc_cnt, 8);
    check({tag, "_busy_cycles"}, busy_cyc, v.exp_busy);
    check({tag, "_leftover"}, exp_q.size(), 0);
    repeat (4) tick();
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_tail_err_hold"}, int'(tail_err), int'(v.exp_err));
    check({tag, "_idle_busy"}, int'(busy), 0);
    tail_at = -1;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{8'hA5, 0, -1, 0,  8, 59, 1'b0};
    vecs[1] = '{8'hA5, 3, -1, 0,  8, 62, 1'b0};
    vecs[2] = '{8'h3C, 0,  9, 0,  8, 59, 1'b1};
    vecs[3] = '{8'h5A, 0, -1, 0,  8, 59, 1'b0};
    vecs[4] = '{8'h69, 0, -1, 20, 9, 59, 1'b0};
    clear_sb();
    h4 = 4'h0; n4 = 0; acc4 = 0; done4_cnt = 0;

    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cfg_ready), 0);
    check("rst_shift_en", int'(chain_shift_en), 0);
    check("rst_tail_err", int'(tail_err), 0);
    check("rst_bit_cnt", int'(bit_cnt), 0);
    pReset = 1'b0;
    tick();

    for (int r = 0; r < 5; r++) run_load(vecs[r], $sformatf("row%0d", r));

    // Reset in the middle of a load, then a clean full load.
    clear_sb();
    cfg_data = 8'hC3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1;
    cyc = 0;
    while (int'(bit_cnt) != 30 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("midrst_reached_30", int'(bit_cnt), 30);
    pReset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_shift_en", int'(chain_shift_en), 0);
    check("midrst_ready", int'(cfg_ready), 0);
    check("midrst_bit_cnt", int'(bit_cnt), 0);
    cfg_valid = 1'b0;
    tick();
    pReset = 1'b0;
    tick();
    run_load(vecs[0], "after_rst");

    // Four-flop chain with one 8-bit word: only the top nibble is shifted.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cfg_data4 = 8'hF0;
    cfg_valid4 = 1'b1;
    cyc = 0;
    while (done4_cnt == 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    cfg_valid4 = 1'b0;
    tick();
    check("len4_bits", int'(h4), 15);
    check("len4_shifts", n4, 4);
    check("len4_words", acc4, 1);
    check("len4_bit_cnt", int'(bit_cnt4), 4);
    check("len4_done", done4_cnt, 1);
    check("len4_tail_err", int'(tail_err4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
